// File: rtl/booth_pkg.sv
// Shared constants for the radix-4 Booth sequential multiplier: FSM encoding,
// default operand/product widths and the 3-bit Booth digit codes.
package booth_pkg;

    localparam int BOOTH_OP_W   = 12;
    localparam int BOOTH_PROD_W = 2 * BOOTH_OP_W;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_ADD  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Digit window {b[2k+1], b[2k], b[2k-1]}
    localparam logic [2:0] DIG_Z0  = 3'b000;
    localparam logic [2:0] DIG_P1A = 3'b001;
    localparam logic [2:0] DIG_P1B = 3'b010;
    localparam logic [2:0] DIG_P2  = 3'b011;
    localparam logic [2:0] DIG_N2  = 3'b100;
    localparam logic [2:0] DIG_N1A = 3'b101;
    localparam logic [2:0] DIG_N1B = 3'b110;
    localparam logic [2:0] DIG_Z1  = 3'b111;

endpackage

// File: rtl/booth_cla_add.sv
// W-bit carry-lookahead adder built from 4-bit lookahead groups with a
// rippled group carry; carry-out is not produced. W must be a multiple of 4.
module booth_cla_add #(
    parameter int W = 24
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         cin,
    output logic [W-1:0] sum
);
    localparam int NG = W / 4;

    logic [NG-1:0] gc;

    assign gc[0] = cin;

    generate
        for (genvar gi = 0; gi < NG; gi++) begin : g_grp
            logic [2:0] g;
            logic [3:0] p;
            logic [3:0] c;

            assign g = x[4*gi +: 3] & y[4*gi +: 3];
            assign p = x[4*gi +: 4] ^ y[4*gi +: 4];

            assign c[0] = gc[gi];
            assign c[1] = g[0] | (p[0] & gc[gi]);
            assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & gc[gi]);
            assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                        | (p[2] & p[1] & p[0] & gc[gi]);

            assign sum[4*gi +: 4] = p ^ c;

            // The top group's carry-out is discarded, so it is not built
            if (gi < NG - 1) begin : g_next
                logic g3;
                assign g3 = x[4*gi+3] & y[4*gi+3];
                assign gc[gi+1] = g3 | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                                | (p[3] & p[2] & p[1] & g[0]) | ((&p) & gc[gi]);
            end
        end
    endgenerate

endmodule

// File: rtl/booth_pp_gen.sv
// Combinational Booth partial-product generator: maps one radix-4 digit to a
// shifted PROD_W-bit addend; negative digits come out inverted with cin=1.
module booth_pp_gen
    import booth_pkg::*;
#(
    parameter int OP_W = BOOTH_OP_W
) (
    input  logic [OP_W-1:0]   a,
    input  logic [2:0]        digit,
    input  logic [2:0]        k,
    output logic [2*OP_W-1:0] pp,
    output logic              cin
);
    localparam int PROD_W = 2 * OP_W;

    logic [PROD_W-1:0] a_ext;
    logic [PROD_W-1:0] mag;
    logic [PROD_W-1:0] shifted;
    logic              neg;

    assign a_ext = {{OP_W{a[OP_W-1]}}, a};

    always_comb begin
        mag = '0;
        neg = 1'b0;
        case (digit)
            DIG_Z0, DIG_Z1:   mag = '0;
            DIG_P1A, DIG_P1B: mag = a_ext;
            DIG_P2:           mag = a_ext << 1;
            DIG_N2: begin
                mag = a_ext << 1;
                neg = 1'b1;
            end
            DIG_N1A, DIG_N1B: begin
                mag = a_ext;
                neg = 1'b1;
            end
            default:          mag = '0;
        endcase
    end

    assign shifted = mag << {k, 1'b0};
    // -(x) == ~x + 1: the +1 rides in on the adder carry-in
    assign pp  = neg ? ~shifted : shifted;
    assign cin = neg;

endmodule

// File: rtl/booth_seq_mult_ctrl.sv
// Sequential radix-4 Booth multiplier: IDLE -> LOAD -> ADD x OP_W/2 -> DONE.
// Define BOOTH_MAC_EN to add acc_clr and accumulate onto the previous product.
module booth_seq_mult_ctrl
    import booth_pkg::*;
#(
    parameter int OP_W = BOOTH_OP_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
`ifdef BOOTH_MAC_EN
    input  logic              acc_clr,
`endif
    output logic              busy,
    output logic              done,
    output logic [2*OP_W-1:0] product,
    output logic [2:0]        step
);
    localparam int         PROD_W    = 2 * OP_W;
    localparam logic [2:0] LAST_STEP = 3'(OP_W / 2 - 1);

    logic [1:0]        state_reg, state_next;
    logic [OP_W-1:0]   a_reg, a_next;
    logic [OP_W:0]     b_reg, b_next;
    logic [PROD_W-1:0] acc_reg, acc_next;
    logic [PROD_W-1:0] product_reg, product_next;
    logic [2:0]        step_reg, step_next;
    logic [PROD_W-1:0] pp;
    logic [PROD_W-1:0] sum;
    logic [PROD_W-1:0] acc_init;
    logic              pp_cin;
    logic              accept;

    assign accept = start && (state_reg == ST_IDLE || state_reg == ST_DONE);

`ifdef BOOTH_MAC_EN
    assign acc_init = acc_clr ? '0 : product_reg;
`else
    assign acc_init = '0;
`endif

    // Digit window sits in b_reg[2:0]; b_reg shifts right by 2 per ADD cycle
    booth_pp_gen #(
        .OP_W (OP_W)
    ) u_pp_gen (
        .a     (a_reg),
        .digit (b_reg[2:0]),
        .k     (step_reg),
        .pp    (pp),
        .cin   (pp_cin)
    );

    booth_cla_add #(
        .W (PROD_W)
    ) u_add (
        .x   (acc_reg),
        .y   (pp),
        .cin (pp_cin),
        .sum (sum)
    );

    always_comb begin
        state_next   = state_reg;
        a_next       = a_reg;
        b_next       = b_reg;
        acc_next     = acc_reg;
        product_next = product_reg;
        step_next    = step_reg;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    state_next = ST_LOAD;
                    a_next     = a;
                    b_next     = {b, 1'b0};
                    acc_next   = acc_init;
                    step_next  = '0;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_LOAD: state_next = ST_ADD;
            ST_ADD: begin
                acc_next = sum;
                b_next   = {{2{b_reg[OP_W]}}, b_reg[OP_W:2]};
                if (step_reg == LAST_STEP) begin
                    state_next   = ST_DONE;
                    product_next = sum;
                    step_next    = '0;
                end else begin
                    step_next = step_reg + 3'd1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            a_reg       <= '0;
            b_reg       <= '0;
            acc_reg     <= '0;
            product_reg <= '0;
            step_reg    <= '0;
        end else begin
            state_reg   <= state_next;
            a_reg       <= a_next;
            b_reg       <= b_next;
            acc_reg     <= acc_next;
            product_reg <= product_next;
            step_reg    <= step_next;
        end
    end

    assign busy    = (state_reg == ST_LOAD) || (state_reg == ST_ADD);
    assign done    = (state_reg == ST_DONE);
    assign product = product_reg;
    assign step    = step_reg;

endmodule

// File: tb/tb_booth_seq_mult_ctrl.sv
// Directed self-checking bench for booth_seq_mult_ctrl (default OP_W=12);
// the accumulate sequence runs only when BOOTH_MAC_EN is defined.
module tb_booth_seq_mult_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [11:0] a;
    logic [11:0] b;
`ifdef BOOTH_MAC_EN
    logic        acc_clr;
`endif
    logic        busy;
    logic        done;
    logic [23:0] product;
    logic [2:0]  step;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    booth_seq_mult_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
`ifdef BOOTH_MAC_EN
        .acc_clr (acc_clr),
`endif
        .busy    (busy),
        .done    (done),
        .product (product),
        .step    (step)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present operands with start for one cycle (cycle 0); returns in cycle 1
    task automatic launch(input logic [11:0] av, input logic [11:0] bv);
        a     = av;
        b     = bv;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Checks cycles 1..7 (LOAD, ADD x6) and the done cycle 8; returns in cycle 8
    task automatic finish_op(input logic [23:0] exp, input string tag);
        for (int c = 1; c < 8; c++) begin
            chk({tag, "_busy"}, busy, 1);
            chk({tag, "_nodone"}, done, 0);
            chk({tag, "_step"}, step, (c < 2) ? 0 : c - 2);
            tick();
        end
        chk({tag, "_done"}, done, 1);
        chk({tag, "_idlebusy"}, busy, 0);
        chk({tag, "_product"}, product, exp);
        $display("op %s: product=0x%06h expected=0x%06h", tag, product, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
`ifdef BOOTH_MAC_EN
        acc_clr = 1'b1;
`endif
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_product", product, 0);
        chk("rst_step", step, 0);
        rst = 1'b0;
        tick();

        // Basic products and corner operands
        launch(12'd3, 12'd5);
        finish_op(24'h00000F, "3x5");
        tick();
        chk("3x5_pulse_end", done, 0);
        chk("3x5_hold", product, 24'h00000F);

        launch(12'h800, 12'h800);
        finish_op(24'h400000, "min_x_min");
        tick();
        launch(12'h800, 12'h7FF);
        finish_op(24'hC00800, "min_x_max");
        tick();
        launch(12'h7FF, 12'h7FF);
        finish_op(24'h3FF001, "max_x_max");
        tick();
        launch(12'hFFD, 12'd5);
        finish_op(24'hFFFFF1, "m3x5");
        tick();

        // start pulses and operand changes mid-operation are ignored
        launch(12'd3, 12'd5);
        for (int c = 1; c < 8; c++) begin
            a     = 12'd9 + 12'(c);
            b     = 12'd9;
            start = (c == 3 || c == 5);
            chk("ign_busy", busy, 1);
            chk("ign_nodone", done, 0);
            tick();
        end
        start = 1'b0;
        chk("ign_done", done, 1);
        chk("ign_product", product, 24'h00000F);
        $display("op ignore_start: product=0x%06h expected=0x00000f", product);
        tick();
        chk("ign_single_done", done, 0);
        chk("ign_idle", busy, 0);

        // Reset mid-operation aborts without a done pulse
        launch(12'd3, 12'd5);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_product", product, 0);
        chk("abort_step", step, 0);
        $display("op abort: busy=%0d done=%0d product=0x%06h", busy, done, product);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            chk("abort_nodone", done, 0);
            tick();
        end
        launch(12'd7, 12'hFFF);
        finish_op(24'hFFFFF9, "7xm1");
        tick();

        // Back-to-back: start held in DONE relaunches immediately
        launch(12'd3, 12'd5);
        finish_op(24'h00000F, "b2b_first");
        a     = 12'd2;
        b     = 12'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        finish_op(24'h000008, "b2b_second");
        tick();
        chk("b2b_end", done, 0);

`ifdef BOOTH_MAC_EN
        acc_clr = 1'b1;
        launch(12'd3, 12'd5);
        finish_op(24'h00000F, "mac_clr");
        tick();
        acc_clr = 1'b0;
        launch(12'd2, 12'd4);
        finish_op(24'h000017, "mac_acc");
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
